bank_biu_writeback_unit: RTL and testbench

Sink for the bank SRAM controller's write-back channel (sc_biu_*). Accepts 256-bit write-back cachelines (two 128-bit offsets with per-byte strobes) through a valid/ready handshake and buffers them in a small FIFO. Drains each entry to the sub-memory write port as one or two 128-bit beats, skipping any offset whose 16 strobe bits are all zero. Sits between the bank's SRAM controller and the sub-memory.

---
 rtl/bank_biu_writeback_unit.sv | 127 ++++++++++++
 tb/tb_bank_biu_writeback_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_biu_writeback_unit.sv
// Write-back sink: buffers 256-bit cachelines from the bank SRAM controller and
// drains them to sub-memory as up to two 128-bit beats, skipping empty offsets.
module bank_biu_writeback_unit #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sc_biu_valid_i,
    output logic         sc_biu_ready_o,
    input  logic [255:0] sc_biu_data_i,
    input  logic [31:0]  sc_biu_strb_i,
    input  logic [5:0]   sc_biu_set_way_i,
    output logic         mem_wr_valid_o,
    input  logic         mem_wr_ready_i,
    output logic [6:0]   mem_wr_addr_o,
    output logic [127:0] mem_wr_data_o,
    output logic [15:0]  mem_wr_strb_o,
    output logic         mem_wr_last_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [255:0]     r_data    [DEPTH];
    logic [31:0]      r_strb    [DEPTH];
    logic [5:0]       r_set_way [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    state_t           r_state, w_state_nxt;

    logic         w_push, w_pop, w_nonempty;
    logic [255:0] w_head_data;
    logic [31:0]  w_head_strb;
    logic [5:0]   w_head_set_way;
    logic         w_lo_any, w_hi_any;

    assign w_nonempty     = (r_count != '0);
    assign w_head_data    = r_data[r_rd_ptr];
    assign w_head_strb    = r_strb[r_rd_ptr];
    assign w_head_set_way = r_set_way[r_rd_ptr];
    assign w_lo_any       = (w_head_strb[15:0] != '0);
    assign w_hi_any       = (w_head_strb[31:16] != '0);

    // Ready comes from the registered count only; a same-cycle pop never frees a slot early.
    assign sc_biu_ready_o = (r_count != FULL_CNT) & ~rst_i;
    assign w_push         = sc_biu_valid_i & sc_biu_ready_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wr_ptr]    <= sc_biu_data_i;
            r_strb[r_wr_ptr]    <= sc_biu_strb_i;
            r_set_way[r_wr_ptr] <= sc_biu_set_way_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    if (w_lo_any)      w_state_nxt = S_BEAT0;
                    else if (w_hi_any) w_state_nxt = S_BEAT1;
                    else               w_pop       = 1'b1;
                end
            end
            S_BEAT0: begin
                if (mem_wr_ready_i) begin
                    if (w_hi_any) begin
                        w_state_nxt = S_BEAT1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_pop       = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_wr_ready_i) begin
                    w_state_nxt = S_IDLE;
                    w_pop       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_wr_valid_o = (r_state != S_IDLE);
        mem_wr_addr_o  = {w_head_set_way, r_state == S_BEAT1};
        mem_wr_data_o  = w_head_data[127:0];
        mem_wr_strb_o  = w_head_strb[15:0];
        mem_wr_last_o  = 1'b0;
        if (r_state == S_BEAT1) begin
            mem_wr_data_o = w_head_data[255:128];
            mem_wr_strb_o = w_head_strb[31:16];
            mem_wr_last_o = 1'b1;
        end else if (r_state == S_BEAT0) begin
            mem_wr_last_o = ~w_hi_any;
        end
        busy_o = w_nonempty | (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_bank_biu_writeback_unit.sv
// Directed bench for bank_biu_writeback_unit: table of single-entry vectors plus
// hand-written backpressure, full-FIFO and reset-mid-beat sequences.
module tb_bank_biu_writeback_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         sc_biu_valid_i;
    logic         sc_biu_ready_o;
    logic [255:0] sc_biu_data_i;
    logic [31:0]  sc_biu_strb_i;
    logic [5:0]   sc_biu_set_way_i;
    logic         mem_wr_valid_o;
    logic         mem_wr_ready_i;
    logic [6:0]   mem_wr_addr_o;
    logic [127:0] mem_wr_data_o;
    logic [15:0]  mem_wr_strb_o;
    logic         mem_wr_last_o;
    logic         busy_o;

    bank_biu_writeback_unit #(.DEPTH(2), .PTR_W(1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .sc_biu_valid_i   (sc_biu_valid_i),
        .sc_biu_ready_o   (sc_biu_ready_o),
        .sc_biu_data_i    (sc_biu_data_i),
        .sc_biu_strb_i    (sc_biu_strb_i),
        .sc_biu_set_way_i (sc_biu_set_way_i),
        .mem_wr_valid_o   (mem_wr_valid_o),
        .mem_wr_ready_i   (mem_wr_ready_i),
        .mem_wr_addr_o    (mem_wr_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_wr_strb_o    (mem_wr_strb_o),
        .mem_wr_last_o    (mem_wr_last_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]   sw;
        logic [31:0]  strb;
        logic [255:0] data;
        int           nb;
        logic [6:0]   a0;
        logic [127:0] d0;
        logic [15:0]  s0;
        logic         l0;
        logic [6:0]   a1;
        logic [127:0] d1;
        logic [15:0]  s1;
    } vec_t;

    vec_t vecs[5];

    task automatic push(input logic [5:0] sw, input logic [31:0] strb, input logic [255:0] data);
        sc_biu_valid_i   = 1'b1;
        sc_biu_set_way_i = sw;
        sc_biu_strb_i    = strb;
        sc_biu_data_i    = data;
    endtask

    task automatic chk_beat(input string nm, input logic [6:0] a, input logic [127:0] d,
                            input logic [15:0] s, input logic l);
        chk({nm, "_valid"}, mem_wr_valid_o, 1);
        chk({nm, "_addr"},  mem_wr_addr_o,  a);
        chk({nm, "_data"},  mem_wr_data_o,  d);
        chk({nm, "_strb"},  mem_wr_strb_o,  s);
        chk({nm, "_last"},  mem_wr_last_o,  l);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        chk("ready_before_push", sc_biu_ready_o, 1);
        push(v.sw, v.strb, v.data);
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;
        chk("bubble_valid", mem_wr_valid_o, 0);
        chk("busy_after_accept", busy_o, 1);
        @(negedge clk_i);
        if (v.nb >= 1) begin
            chk_beat("beat_a", v.a0, v.d0, v.s0, v.l0);
            @(negedge clk_i);
        end
        if (v.nb == 2) begin
            chk_beat("beat_b", v.a1, v.d1, v.s1, 1'b1);
            @(negedge clk_i);
        end
        chk("valid_after_entry", mem_wr_valid_o, 0);
        chk("busy_after_entry", busy_o, 0);
    endtask

    initial begin
        vecs[0] = '{6'h15, 32'hFFFF_FFFF, {{16{8'hBB}}, {16{8'hAA}}}, 2,
                    7'h2A, {16{8'hAA}}, 16'hFFFF, 1'b0, 7'h2B, {16{8'hBB}}, 16'hFFFF};
        vecs[1] = '{6'h03, 32'hFFFF_0000, {{16{8'hCC}}, {16{8'hDD}}}, 1,
                    7'h07, {16{8'hCC}}, 16'hFFFF, 1'b1, 7'h00, '0, '0};
        vecs[2] = '{6'h3F, 32'h0000_00F0, {{16{8'hEE}}, {8{16'h1234}}}, 1,
                    7'h7E, {8{16'h1234}}, 16'h00F0, 1'b1, 7'h00, '0, '0};
        vecs[3] = '{6'h2A, 32'h0000_0000, {{16{8'h55}}, {16{8'h66}}}, 0,
                    7'h00, '0, '0, 1'b0, 7'h00, '0, '0};
        vecs[4] = '{6'h00, 32'h8000_0001, {{16{8'h99}}, {16{8'h77}}}, 2,
                    7'h00, {16{8'h77}}, 16'h0001, 1'b0, 7'h01, {16{8'h99}}, 16'h8000};

        rst_i            = 1'b1;
        sc_biu_valid_i   = 1'b0;
        sc_biu_data_i    = '0;
        sc_biu_strb_i    = '0;
        sc_biu_set_way_i = '0;
        mem_wr_ready_i   = 1'b1;
        #1;
        chk("rst_valid", mem_wr_valid_o, 0);
        chk("rst_last",  mem_wr_last_o,  0);
        chk("rst_busy",  busy_o,         0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_release_ready", sc_biu_ready_o, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: hold ready low through 5 cycles of BEAT0.
        @(negedge clk_i);
        mem_wr_ready_i = 1'b0;
        push(6'h15, 32'hFFFF_FFFF, {{16{8'hBB}}, {16{8'hAA}}});
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;
        chk("bp_bubble", mem_wr_valid_o, 0);
        @(negedge clk_i);
        for (int c = 0; c < 5; c++) begin
            chk_beat("bp_hold", 7'h2A, {16{8'hAA}}, 16'hFFFF, 1'b0);
            @(negedge clk_i);
        end
        mem_wr_ready_i = 1'b1;
        chk_beat("bp_release", 7'h2A, {16{8'hAA}}, 16'hFFFF, 1'b0);
        @(negedge clk_i);
        chk_beat("bp_beat1", 7'h2B, {16{8'hBB}}, 16'hFFFF, 1'b1);
        @(negedge clk_i);
        chk("bp_done_busy", busy_o, 0);

        // Full FIFO: three single-beat entries, third must wait for the first pop.
        mem_wr_ready_i = 1'b0;
        push(6'h01, 32'h0000_0001, {{16{8'h00}}, {16{8'h11}}});
        @(negedge clk_i);
        chk("ff_ready_one", sc_biu_ready_o, 1);
        push(6'h02, 32'h0000_0001, {{16{8'h00}}, {16{8'h22}}});
        @(negedge clk_i);
        chk("ff_ready_full", sc_biu_ready_o, 0);
        chk_beat("ff_head_wait", 7'h02, {16{8'h11}}, 16'h0001, 1'b1);
        push(6'h03, 32'h0000_0001, {{16{8'h00}}, {16{8'h33}}});
        @(negedge clk_i);
        chk("ff_third_waits", sc_biu_ready_o, 0);
        mem_wr_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ff_ready_after_pop", sc_biu_ready_o, 1);
        chk("ff_bubble", mem_wr_valid_o, 0);
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;
        chk_beat("ff_second", 7'h04, {16{8'h22}}, 16'h0001, 1'b1);
        @(negedge clk_i);
        chk("ff_bubble2", mem_wr_valid_o, 0);
        chk("ff_busy_mid", busy_o, 1);
        @(negedge clk_i);
        chk_beat("ff_third", 7'h06, {16{8'h33}}, 16'h0001, 1'b1);
        @(negedge clk_i);
        chk("ff_done_busy", busy_o, 0);

        // Reset in BEAT1 with a second entry still buffered.
        mem_wr_ready_i = 1'b0;
        push(6'h15, 32'hFFFF_FFFF, {{16{8'hBB}}, {16{8'hAA}}});
        @(negedge clk_i);
        push(6'h09, 32'hFFFF_FFFF, {{16{8'h44}}, {16{8'h88}}});
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;
        chk("rb_beat0_addr", mem_wr_addr_o, 7'h2A);
        mem_wr_ready_i = 1'b1;
        @(negedge clk_i);
        mem_wr_ready_i = 1'b0;
        chk_beat("rb_beat1", 7'h2B, {16{8'hBB}}, 16'hFFFF, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("rb_valid", mem_wr_valid_o, 0);
        chk("rb_last",  mem_wr_last_o,  0);
        chk("rb_busy",  busy_o,         0);
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_wr_ready_i = 1'b1;
        #1;
        chk("rb_ready", sc_biu_ready_o, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("rb_no_beats", mem_wr_valid_o, 0);
            chk("rb_idle_busy", busy_o, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
